// File: rtl/wptr_full_gen.sv
// Write-domain pointer/flag generator for an async FIFO: binary + Gray write
// pointer, full / almost-full / level from the synchronized read pointer, sticky overflow.
module wptr_full_gen #(
    parameter int ADDR_W   = 4,
    parameter int AFULL_TH = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              winc,
    input  logic [ADDR_W:0]   wq2_rptr,
    input  logic              wovf_clr,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr,
    output logic              wfull,
    output logic              walmost_full,
    output logic [ADDR_W:0]   wlevel,
    output logic              wovf
);

    localparam int unsigned     C_PW        = ADDR_W + 1;
    localparam int unsigned     C_DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] C_AFULL_LVL = (ADDR_W + 1)'(C_DEPTH - AFULL_TH);

    logic [ADDR_W:0]   r_wbin;
    logic [ADDR_W:0]   r_wptr;
    logic              r_wfull;
    logic              r_wafull;
    logic [ADDR_W:0]   r_wlevel;
    logic              r_wovf;

    logic              w_wen;
    logic [ADDR_W:0]   w_wbin_next;
    logic [ADDR_W:0]   w_wgray_next;
    logic [ADDR_W:0]   w_rbin;
    logic [ADDR_W:0]   w_level_next;
    logic              w_full_next;
    logic              w_afull_next;

    assign w_wen        = winc & ~r_wfull;
    assign w_wbin_next  = r_wbin + {{ADDR_W{1'b0}}, w_wen};
    assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_rbin = '0;
        for (int unsigned i = 0; i < C_PW; i++) begin
            w_rbin[i] = ^(wq2_rptr >> i);
        end
    end

    assign w_level_next = w_wbin_next - w_rbin;
    assign w_full_next  = (w_wgray_next ==
                           {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]});
    assign w_afull_next = w_full_next | (w_level_next >= C_AFULL_LVL);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wbin   <= '0;
            r_wptr   <= '0;
            r_wfull  <= 1'b0;
            r_wafull <= 1'b0;
            r_wlevel <= '0;
            r_wovf   <= 1'b0;
        end else begin
            r_wbin   <= w_wbin_next;
            r_wptr   <= w_wgray_next;
            r_wfull  <= w_full_next;
            r_wafull <= w_afull_next;
            r_wlevel <= w_level_next;
            // A violation in the clearing cycle keeps the flag set.
            r_wovf   <= (winc & r_wfull) | (r_wovf & ~wovf_clr);
        end
    end

    assign waddr        = r_wbin[ADDR_W-1:0];
    assign wptr         = r_wptr;
    assign wfull        = r_wfull;
    assign walmost_full = r_wafull;
    assign wlevel       = r_wlevel;
    assign wovf         = r_wovf;

endmodule
